// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [1:0] ST_REQ   = FETCH_REQ;
    localparam logic [1:0] ST_HOLD  = FETCH_HOLD;
    localparam logic [1:0] ST_DRAIN = FETCH_DRAIN;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry instruction/PC buffer with load, pop and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t load_entry,
    output logic         full,
    output fetch_entry_t entry
);

    // Flush wins over load so a redirect never leaves a stale word behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            entry.instr <= NOP_INSTR;
            entry.pc    <= 32'h0000_0000;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : RISC-V instruction fetch stage: PC, I-cache request handshake,
//               output register plus one-entry skid, redirect flush.
//               Optional miss-cycle counter enabled by IFU_MISS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
`ifdef IFU_MISS_CNT_EN
    ,
    output logic [31:0] miss_cycles
`endif
);

    logic [1:0]   state;
    logic [31:0]  pc;
    logic         consume;
    logic         skid_load;
    logic         skid_pop;
    logic         skid_full;
    fetch_entry_t skid_in;
    fetch_entry_t skid_out;

    assign consume = instr_valid & ~stall;
    assign ic_req  = (state != ST_HOLD);

    always_comb begin
        skid_in.instr = ic_rdata;
        skid_in.pc    = ic_addr;
        skid_load     = (state == ST_REQ) && ic_ready && !redirect && instr_valid && stall;
        skid_pop      = (state == ST_HOLD) && consume && !redirect && skid_full;
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .pop        (skid_pop),
        .flush      (redirect),
        .load_entry (skid_in),
        .full       (skid_full),
        .entry      (skid_out)
    );

    // pc always holds the address to request after the current ic_addr,
    // except in DRAIN where it holds the pending redirect target itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            ic_addr     <= RESET_PC;
            pc          <= next_pc(RESET_PC);
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
        end else if (redirect) begin
            instr_valid <= 1'b0;
            if (ic_req && !ic_ready) begin
                state <= ST_DRAIN;
                pc    <= redirect_pc;
            end else begin
                state   <= ST_REQ;
                ic_addr <= redirect_pc;
                pc      <= next_pc(redirect_pc);
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (ic_ready) begin
                        ic_addr <= pc;
                        pc      <= next_pc(pc);
                        if (!instr_valid || !stall) begin
                            instr       <= ic_rdata;
                            instr_pc    <= ic_addr;
                            instr_valid <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else if (consume) begin
                        instr_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (skid_pop) begin
                        instr    <= skid_out.instr;
                        instr_pc <= skid_out.pc;
                        state    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (ic_ready) begin
                        ic_addr <= pc;
                        pc      <= next_pc(pc);
                        state   <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

`ifdef IFU_MISS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cycles <= 32'h0000_0000;
        end else if (ic_req && !ic_ready && (miss_cycles != 32'hFFFF_FFFF)) begin
            miss_cycles <= miss_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed vector table
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          NVEC   = 33;
    localparam int          NRAND  = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef IFU_MISS_CNT_EN
    logic [31:0] miss_cycles;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_ready    (ic_ready),
        .ic_rdata    (ic_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
`ifdef IFU_MISS_CNT_EN
        ,
        .miss_cycles (miss_cycles)
`endif
    );

    typedef struct {
        bit          rdy;
        bit          stl;
        bit          rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[NVEC];
    int   checks = 0;
    int   passes = 0;

    // Cache contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic set_row(input int i, input bit rdy, input bit stl, input bit rdr,
                           input logic [31:0] rpc, input bit er, input logic [31:0] ea,
                           input bit ev, input logic [31:0] ep);
        tbl[i] = '{rdy, stl, rdr, rpc, er, ea, ev, ep};
    endtask

    task automatic do_reset();
        rst = 1'b1; ic_ready = 1'b0; ic_rdata = 32'h0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] m_addr;
    logic [31:0] m_pend;
    bit          m_drain;
    int          m_miss;

    initial begin
        //          i  rdy stl rdr rpc            req addr           val pc
        set_row( 0, 1, 0, 0, 32'h0,        1, 32'h100,        0, 32'h0);
        set_row( 1, 1, 0, 0, 32'h0,        1, 32'h104,        1, 32'h100);
        set_row( 2, 1, 0, 0, 32'h0,        1, 32'h108,        1, 32'h104);
        set_row( 3, 0, 0, 0, 32'h0,        1, 32'h10C,        1, 32'h108);
        set_row( 4, 0, 0, 0, 32'h0,        1, 32'h10C,        0, 32'h0);
        set_row( 5, 0, 0, 0, 32'h0,        1, 32'h10C,        0, 32'h0);
        set_row( 6, 0, 0, 0, 32'h0,        1, 32'h10C,        0, 32'h0);
        set_row( 7, 0, 0, 0, 32'h0,        1, 32'h10C,        0, 32'h0);
        set_row( 8, 1, 0, 0, 32'h0,        1, 32'h10C,        0, 32'h0);
        set_row( 9, 1, 1, 0, 32'h0,        1, 32'h110,        1, 32'h10C);
        set_row(10, 1, 1, 0, 32'h0,        0, 32'h114,        1, 32'h10C);
        set_row(11, 1, 1, 0, 32'h0,        0, 32'h114,        1, 32'h10C);
        set_row(12, 1, 1, 0, 32'h0,        0, 32'h114,        1, 32'h10C);
        set_row(13, 1, 0, 0, 32'h0,        0, 32'h114,        1, 32'h10C);
        set_row(14, 1, 0, 0, 32'h0,        1, 32'h114,        1, 32'h110);
        set_row(15, 0, 0, 0, 32'h0,        1, 32'h118,        1, 32'h114);
        set_row(16, 0, 0, 1, 32'h200,      1, 32'h118,        0, 32'h0);
        set_row(17, 0, 0, 0, 32'h0,        1, 32'h118,        0, 32'h0);
        set_row(18, 1, 0, 0, 32'h0,        1, 32'h118,        0, 32'h0);
        set_row(19, 1, 0, 0, 32'h0,        1, 32'h200,        0, 32'h0);
        set_row(20, 1, 1, 1, 32'h300,      1, 32'h204,        1, 32'h200);
        set_row(21, 1, 0, 0, 32'h0,        1, 32'h300,        0, 32'h0);
        set_row(22, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h304,       1, 32'h300);
        set_row(23, 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,  0, 32'h0);
        set_row(24, 1, 0, 0, 32'h0,        1, 32'h0,          1, 32'hFFFF_FFFC);
        set_row(25, 0, 0, 1, 32'h400,      1, 32'h4,          1, 32'h0);
        set_row(26, 0, 0, 1, 32'h500,      1, 32'h4,          0, 32'h0);
        set_row(27, 1, 0, 0, 32'h0,        1, 32'h4,          0, 32'h0);
        set_row(28, 1, 0, 0, 32'h0,        1, 32'h500,        0, 32'h0);
        set_row(29, 1, 1, 0, 32'h0,        1, 32'h504,        1, 32'h500);
        set_row(30, 0, 1, 1, 32'h600,      0, 32'h508,        1, 32'h500);
        set_row(31, 1, 0, 0, 32'h0,        1, 32'h600,        0, 32'h0);
        set_row(32, 0, 0, 0, 32'h0,        1, 32'h604,        1, 32'h600);

        do_reset();
        check("reset_ic_req", {31'h0, ic_req}, 32'h1);
        check("reset_ic_addr", ic_addr, RST_PC);
        check("reset_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_instr_pc", instr_pc, RST_PC);
`ifdef IFU_MISS_CNT_EN
        check("reset_miss", miss_cycles, 32'h0);
`endif

        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("vec%0d_req", i), {31'h0, ic_req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), ic_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_val});
            if (tbl[i].e_val) begin
                check($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
                check($sformatf("vec%0d_instr", i), instr, mem_word(tbl[i].e_pc));
            end
            ic_ready    = tbl[i].rdy;
            ic_rdata    = tbl[i].rdy ? mem_word(tbl[i].e_addr) : 32'hDEAD_BEEF;
            stall       = tbl[i].stl;
            redirect    = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
        end
`ifdef IFU_MISS_CNT_EN
        check("vec_miss_total", miss_cycles, 32'd11);
`endif

        // Randomized traffic: the model is the in-order stream of fetched
        // words waiting for decode (at most two) plus the next request address.
        do_reset();
        q.delete();
        m_addr  = RST_PC;
        m_pend  = 32'h0;
        m_drain = 1'b0;
        m_miss  = 0;
        for (int c = 0; c < NRAND; c++) begin
            bit exp_req;
            bit rdy;
            bit stl;
            bit rdr;
            bit cons;
            logic [31:0] rpc;
            exp_req = m_drain || (q.size() < 2);
            check("rnd_req", {31'h0, ic_req}, {31'h0, exp_req});
            if (exp_req) check("rnd_addr", ic_addr, m_addr);
            check("rnd_valid", {31'h0, instr_valid}, {31'h0, (q.size() > 0)});
            if (q.size() > 0) begin
                check("rnd_pc", instr_pc, q[0]);
                check("rnd_instr", instr, mem_word(q[0]));
            end

            rdy = ($urandom_range(3) != 0);
            stl = ($urandom_range(2) == 0);
            rdr = ($urandom_range(15) == 0);
            rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            ic_ready    = rdy;
            ic_rdata    = rdy ? mem_word(m_addr) : $urandom;
            stall       = stl;
            redirect    = rdr;
            redirect_pc = rpc;

            if (exp_req && !rdy) m_miss++;
            cons = (q.size() > 0) && !stl;
            if (rdr) begin
                q.delete();
                if (exp_req && !rdy) begin
                    m_drain = 1'b1;
                    m_pend  = rpc;
                end else begin
                    m_drain = 1'b0;
                    m_addr  = rpc;
                end
            end else if (m_drain) begin
                if (rdy) begin
                    m_drain = 1'b0;
                    m_addr  = m_pend;
                end
            end else begin
                if (cons) void'(q.pop_front());
                if (exp_req && rdy) begin
                    q.push_back(m_addr);
                    m_addr = m_addr + 32'd4;
                end
            end
            @(negedge clk);
        end
`ifdef IFU_MISS_CNT_EN
        check("rnd_miss_total", miss_cycles, m_miss);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core, directly upstream of decode and immediate sign extension. It owns the program counter and issues word requests to the instruction cache. It holds each request stable until the cache answers, even across a miss. Fetched words go out through an output register with a one-entry skid buffer, whose `instr[31:7]` drives the immediate extender. Redirects from branch/jump resolution flush queued instructions and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ic_req` out 1: cache request, high in REQ and DRAIN.
- `ic_addr` out 32: request address, stable while `ic_req` is high until `ic_ready`.
- `ic_ready` in 1: cache response strobe; `ic_rdata` valid only in this cycle.
- `ic_rdata` in 32: instruction word.
- `stall` in 1: decode cannot accept; output held.
- `redirect` in 1: flush and refetch.
- `redirect_pc` in 32: new fetch address, sampled when `redirect` is high.
- `instr` out 32: instruction to decode/sign extend.
- `instr_pc` out 32: address of `instr`.
- `instr_valid` out 1: `instr`/`instr_pc` valid.

## Operation
- Consume = `instr_valid & ~stall`.
- States:
  - REQ: `ic_req=1`, `ic_addr` = request address.
  - HOLD: no request; output register and skid both full.
  - DRAIN: request outstanding after a redirect; response will be discarded.
- Internal `pc` is the next fetch address. `ic_addr` is its own register, loaded with `pc` when a request starts.
- REQ, `ic_ready=1`, no redirect:
  - If output is empty or consumed this cycle, load `ic_rdata`/`ic_addr` into output and set `instr_valid=1`.
  - Otherwise load the skid and go HOLD.
  - In both cases `pc`/`ic_addr` advance by 4 (wraps mod 2^32).
- REQ, `ic_ready=0`: hold `ic_addr`. Output consume/hold proceeds independently.
- HOLD: on consume, skid moves to output and the state returns to REQ with the next `ic_addr`. The cache never sees a request while HOLD.
- Redirect (priority over stall and `ic_ready`):
  - Clear `instr_valid` and the skid; load `pc` with `redirect_pc`.
  - From REQ with `ic_ready=1`, or from HOLD: next state REQ, `ic_addr=redirect_pc`.
  - From REQ with `ic_ready=0`: next state DRAIN, `ic_addr` unchanged.
- DRAIN: wait for `ic_ready`, discard data, then REQ with `ic_addr=pc`. A further redirect in DRAIN updates `pc` only.
- `redirect_pc[1:0]` is not checked; it is used as given.

## Timing
- Reset values:
  - state REQ; `ic_addr=RESET_PC`; `pc=RESET_PC+4`
  - `instr_valid=0`; `instr=32'h0000_0013` (NOP); `instr_pc=RESET_PC`; skid empty.
- `ic_req` decodes state combinationally, so it is high in the first cycle after `rst` falls.
- Latency: `ic_ready` at cycle t gives `instr_valid` at t+1.
- With hits every cycle and no stall, throughput is one instruction per cycle.
- With `rst` high mid-miss, the outstanding request is abandoned and the cache controller is reset in the same domain.
- `instr`/`instr_pc` are held unchanged while `instr_valid & stall`.

## Configuration
- `IFU_MISS_CNT_EN` defined: adds output `miss_cycles` [31:0].
  - Counts cycles with `ic_req & ~ic_ready` in REQ or DRAIN.
  - Saturates at 32'hFFFF_FFFF; reset to 0.
- `IFU_MISS_CNT_EN` undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - state enum (REQ, HOLD, DRAIN)
  - `NOP_INSTR = 32'h0000_0013`
  - `PC_STEP = 4`
- Sub-module `fetch_skid_buf`: one-entry instruction/PC buffer with load, pop and flush.

## Test plan
- Reset with `RESET_PC=32'h100`, cache ready every cycle, no stall:
  - `ic_addr` 0x100, 0x104, 0x108 on consecutive cycles.
  - `instr_pc` follows one cycle later with `instr_valid` continuous.
- Miss: hold `ic_ready=0` for 5 cycles at 0x104 → `ic_addr` stays 0x104, `instr_valid` drops after 0x100 is consumed; with counter enabled, `miss_cycles=5`.
- Stall 4 cycles while hits continue:
  - Output holds 0x100 and the skid takes 0x104; HOLD with `ic_req=0`.
  - When stall releases, 0x100 then 0x104 are delivered and fetch resumes at 0x108.
- Redirect to 0x200 while the 0x108 request is pending (`ic_ready=0`):
  - DRAIN keeps `ic_addr=0x108` until `ic_ready`; that data is not delivered.
  - The next request is 0x200 and the next valid `instr_pc` is 0x200.
- Redirect to 0x300 simultaneous with `ic_ready` and `stall` in REQ: no valid output next cycle, and the next request is 0x300.
- `pc` wrap: `redirect_pc=32'hFFFF_FFFC` → next request 0x0000_0000.
